layer_loader: RTL

Responder side of the controller's `load_en`/`load_done` handshake. On each load request it copies the current layer's activated neuron outputs from the activation register file into the layer input buffer at that layer's base address, then pulses `load_done`. It tracks the layer index internally: hidden layers first, then the output layer. Optionally, during the output-layer load it computes the predicted class.

---
 rtl/layer_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/layer_loader.sv
// Copies one layer's activations into the input buffer per load_en request; N+2 cycles to load_done (optional argmax: LAYER_LOADER_ARGMAX_EN).
// Dropping load_en mid-load aborts cleanly; a level-held load_en is ignored until it falls after load_done.
module layer_loader #(
    parameter int NO_HL  = 2,
    parameter int NO_NIL = 784,
    parameter int NO_NHL = 28,
    parameter int NO_NOL = 10,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       load_en,
    output logic                       load_done,
    output logic [$clog2(NO_NHL)-1:0]  act_raddr,
    input  logic [DATA_W-1:0]          act_rdata,
    output logic                       buf_we,
    output logic [ADDR_W-1:0]          buf_waddr,
    output logic [DATA_W-1:0]          buf_wdata,
    output logic [$clog2(NO_HL+1)-1:0] layer,
    output logic [$clog2(NO_NOL)-1:0]  pred_class,
    output logic                       pred_valid
);

    localparam int K_W = $clog2(NO_NHL);
    localparam int L_W = $clog2(NO_HL + 1);
    localparam int P_W = $clog2(NO_NOL);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_DONE, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [K_W-1:0]     k, k_last;
    logic [ADDR_W-1:0]  base;
    logic               out_layer;
    logic               k_clr, k_inc, wr_issue, layer_adv;

    always_comb begin
        out_layer = (layer == L_W'(NO_HL));
        k_last    = out_layer ? K_W'(NO_NOL - 1) : K_W'(NO_NHL - 1);
        base      = ADDR_W'(NO_NIL + int'(layer) * NO_NHL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        k_clr     = 1'b0;
        k_inc     = 1'b0;
        wr_issue  = 1'b0;
        layer_adv = 1'b0;
        load_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_en) begin
                    state_nxt = S_READ;
                    k_clr     = 1'b1;
                end
            end
            S_READ: begin
                if (!load_en) begin
                    state_nxt = S_IDLE;
                end else begin
                    wr_issue = 1'b1;
                    if (k == k_last) state_nxt = S_DRAIN;
                    else             k_inc     = 1'b1;
                end
            end
            S_DRAIN: state_nxt = load_en ? S_DONE : S_IDLE;
            S_DONE: begin
                load_done = 1'b1;
                layer_adv = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!load_en) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // start pre-empts everything, including a DONE-cycle layer advance
        if (start) begin
            state_nxt = S_IDLE;
            k_clr     = 1'b0;
            k_inc     = 1'b0;
            wr_issue  = 1'b0;
            layer_adv = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            layer     <= '0;
        end else begin
            if (k_clr)      k <= '0;
            else if (k_inc) k <= k + 1'b1;
            buf_we <= wr_issue;
            if (wr_issue) buf_waddr <= base + ADDR_W'(k);
            if (start)          layer <= '0;
            else if (layer_adv) layer <= out_layer ? '0 : layer + 1'b1;
        end
    end

    // Read data returns one cycle after the index, aligned with the registered write stage.
    assign act_raddr = k;
    assign buf_wdata = buf_we ? act_rdata : '0;

`ifdef LAYER_LOADER_ARGMAX_EN
    logic [K_W-1:0]            wr_k, max_idx, arg_nxt;
    logic signed [DATA_W-1:0]  max_val;
    logic                      take;

    always_comb begin
        take    = (wr_k == '0) || ($signed(buf_wdata) > max_val);
        arg_nxt = take ? wr_k : max_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_k       <= '0;
            max_idx    <= '0;
            max_val    <= '0;
            pred_class <= '0;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            if (wr_issue) wr_k <= k;
            if (buf_we && out_layer && take) begin
                max_val <= $signed(buf_wdata);
                max_idx <= wr_k;
            end
            // Final element is still in flight during DRAIN, so fold it in here.
            if (state == S_DRAIN && state_nxt == S_DONE && out_layer) begin
                pred_class <= P_W'(arg_nxt);
                pred_valid <= 1'b1;
            end
        end
    end
`else
    assign pred_class = '0;
    assign pred_valid = 1'b0;
`endif

endmodule
